fe_ibuf: RTL

FE_IBUF -- requirements
Module: fe_ibuf

---
 rtl/fe_ibuf_pkg.sv | 33 +++
 rtl/fe_ibuf_compact.sv | 33 +++
 rtl/fe_ibuf.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fe_ibuf_pkg.sv
// Shared front-end instruction types and helpers used by the fetch buffer.
package fe_ibuf_pkg;

  localparam int unsigned FE_EPOCH_W = 2;

  typedef logic [FE_EPOCH_W-1:0] t_fe_epoch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } t_instr_pkt;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } t_br_mispred_pkt;

  typedef struct packed {
    logic        valid;
    logic [31:0] target;
  } t_nuke_pkt;

  typedef enum logic {
    StRun      = 1'b0,
    StNukeHold = 1'b1
  } t_ibuf_state;

  // Saturating 32-bit increment for event counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fe_ibuf_compact.sv
// Packs the valid slots of a fetch packet into the low positions, oldest first,
// and reports how many slots survived.
module fe_ibuf_compact
  import fe_ibuf_pkg::*;
#(
  parameter int unsigned FETCH_W = 4
) (
  input  t_instr_pkt [FETCH_W-1:0]           i_slots,
  input  logic       [FETCH_W-1:0]           i_mask,
  output t_instr_pkt [FETCH_W-1:0]           o_slots,
  output logic       [$clog2(FETCH_W+1)-1:0] o_cnt
);

  localparam int unsigned IW = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam int unsigned EW = $clog2(FETCH_W + 1);

  logic [IW-1:0] w_idx;

  // Walk slots in ascending order, dropping each live slot into the next free position.
  always_comb begin
    o_slots = '0;
    o_cnt   = '0;
    w_idx   = '0;
    for (int unsigned i = 0; i < FETCH_W; i++) begin
      if (i_mask[i]) begin
        o_slots[w_idx] = i_slots[i];
        w_idx          = w_idx + IW'(1);
        o_cnt          = o_cnt + EW'(1);
      end
    end
  end

endmodule

// File: rtl/fe_ibuf.sv
// Fetch-to-decode instruction buffer: circular FIFO fed by masked fetch packets,
// drained DEC_W lanes per cycle, flushed by mispredict/nuke with epoch tagging.
// Optional statistics counters are built when FE_IBUF_STATS_EN is defined.
module fe_ibuf
  import fe_ibuf_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned FETCH_W = 4,
  parameter int unsigned DEC_W   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         fb_valid_fb1,
  input  logic       [FETCH_W-1:0]     fb_mask_fb1,
  input  t_instr_pkt [FETCH_W-1:0]     fb_instr_fb1,
  input  t_fe_epoch                    fb_epoch_fb1,
  output logic                         ibuf_ready_fb1,
  output t_fe_epoch                    fe_epoch,
  input  t_br_mispred_pkt              br_mispred_ex0,
  input  t_nuke_pkt                    nuke_rb1,
  input  logic                         resume_fetch_rbx,
  input  logic                         decode_ready_de0,
  output logic       [DEC_W-1:0]       valid_fe1,
  output t_instr_pkt [DEC_W-1:0]       instr_fe1
`ifdef FE_IBUF_STATS_EN
  ,
  output logic       [31:0]            stat_empty_cyc,
  output logic       [31:0]            stat_drop_pkt,
  output logic       [31:0]            stat_flush
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned EW = $clog2(FETCH_W + 1);

  t_ibuf_state                 r_state;
  t_ibuf_state                 w_state_nxt;
  logic        [PW-1:0]        r_rd_ptr;
  logic        [PW-1:0]        r_wr_ptr;
  logic        [CW-1:0]        r_count;
  t_fe_epoch                   r_epoch;
  t_instr_pkt                  r_mem [DEPTH];

  t_instr_pkt  [FETCH_W-1:0]   w_cslots;
  logic        [EW-1:0]        w_ccnt;
  logic                        w_nuke;
  logic                        w_flush;
  logic                        w_ready;
  logic                        w_enq;
  logic        [CW-1:0]        w_avail;
  logic        [CW-1:0]        w_deq;
  logic                        w_unused_tgt;

  assign w_unused_tgt = ^{br_mispred_ex0.target, nuke_rb1.target};

  fe_ibuf_compact #(
    .FETCH_W (FETCH_W)
  ) u_compact (
    .i_slots (fb_instr_fb1),
    .i_mask  (fb_mask_fb1),
    .o_slots (w_cslots),
    .o_cnt   (w_ccnt)
  );

  assign w_nuke  = nuke_rb1.valid;
  assign w_flush = br_mispred_ex0.valid | nuke_rb1.valid;

  // Room check uses the occupancy before this cycle's dequeue; held low during reset.
  assign w_ready = reset && (r_state == StRun) &&
                   ((CW'(DEPTH) - r_count) >= CW'(FETCH_W));
  assign ibuf_ready_fb1 = w_ready;
  assign fe_epoch       = r_epoch;

  // An all-zero mask yields w_ccnt==0, which makes the packet a no-op drop.
  assign w_enq = fb_valid_fb1 && w_ready && (fb_epoch_fb1 == r_epoch) && !w_flush &&
                 (w_ccnt != '0);

  assign w_avail = (r_count >= CW'(DEC_W)) ? CW'(DEC_W) : r_count;

  // Decode lanes: contiguous from lane 0, suppressed in nuke hold and in reset.
  always_comb begin
    valid_fe1 = '0;
    instr_fe1 = '0;
    for (int unsigned k = 0; k < DEC_W; k++) begin
      valid_fe1[k] = reset && (r_state == StRun) && (CW'(k) < r_count);
      instr_fe1[k] = r_mem[r_rd_ptr + PW'(k)];
    end
  end

  // Dequeue count equals the number of lanes shown as valid.
  assign w_deq = (decode_ready_de0 && !w_flush && reset && (r_state == StRun)) ? w_avail : '0;

  // Nuke always wins over resume; mispredict alone never changes state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StRun:      if (w_nuke) w_state_nxt = StNukeHold;
      StNukeHold: if (resume_fetch_rbx && !w_nuke) w_state_nxt = StRun;
      default:    w_state_nxt = StRun;
    endcase
  end

  // Control state: FSM, pointers, occupancy and epoch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= StRun;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_epoch  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_epoch  <= r_epoch + t_fe_epoch'(1);
      end else begin
        r_rd_ptr <= r_rd_ptr + PW'(w_deq);
        if (w_enq) begin
          r_wr_ptr <= r_wr_ptr + PW'(w_ccnt);
          r_count  <= r_count + CW'(w_ccnt) - w_deq;
        end else begin
          r_count  <= r_count - w_deq;
        end
      end
    end
  end

  // Data array write; storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      for (int unsigned j = 0; j < FETCH_W; j++) begin
        if (EW'(j) < w_ccnt) begin
          r_mem[r_wr_ptr + PW'(j)] <= w_cslots[j];
        end
      end
    end
  end

`ifdef FE_IBUF_STATS_EN
  logic [31:0] r_stat_empty;
  logic [31:0] r_stat_drop;
  logic [31:0] r_stat_flush;

  // Saturating event counters for empty cycles, stale drops and flushes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_empty <= '0;
      r_stat_drop  <= '0;
      r_stat_flush <= '0;
    end else begin
      r_stat_empty <= sat_inc(r_stat_empty, (r_state == StRun) && (r_count == '0));
      r_stat_drop  <= sat_inc(r_stat_drop,
                              fb_valid_fb1 && !w_flush && (fb_epoch_fb1 != r_epoch));
      r_stat_flush <= sat_inc(r_stat_flush, w_flush);
    end
  end

  assign stat_empty_cyc = r_stat_empty;
  assign stat_drop_pkt  = r_stat_drop;
  assign stat_flush     = r_stat_flush;
`endif

endmodule
